// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU/branch enums and decode helpers.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LB   = 3'd0, F3_LH  = 3'd1, F3_LBU = 3'd4, F3_LHU  = 3'd5;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } br_cond_e;

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic br_cond_e br_decode(input logic [2:0] f3);
        br_cond_e c;
        case (f3)
            F3_BEQ:  c = BR_EQ;
            F3_BNE:  c = BR_NE;
            F3_BLT:  c = BR_LT;
            F3_BGE:  c = BR_GE;
            F3_BLTU: c = BR_LTU;
            F3_BGEU: c = BR_GEU;
            default: c = BR_NONE;
        endcase
        return c;
    endfunction

    function automatic logic br_taken(input br_cond_e c, input logic [31:0] a,
                                      input logic [31:0] b);
        logic t;
        case (c)
            BR_EQ:   t = (a == b);
            BR_NE:   t = (a != b);
            BR_LT:   t = ($signed(a) < $signed(b));
            BR_GE:   t = ($signed(a) >= $signed(b));
            BR_LTU:  t = (a < b);
            BR_GEU:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] size_from_f3(input logic [2:0] f3);
        logic [1:0] s;
        case (f3[1:0])
            2'b00:   s = SZ_BYTE;
            2'b01:   s = SZ_HALF;
            default: s = SZ_WORD;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_LB:   r = {{24{d[7]}}, d[7:0]};
            F3_LH:   r = {{16{d[15]}}, d[15:0]};
            F3_LBU:  r = {24'b0, d[7:0]};
            F3_LHU:  r = {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
module rv32i_regfile (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [32];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/rv32i_top.sv
// Single-cycle RV32I core with separate instruction/data buses.
// Optional bus-ack stalling is enabled by defining RV32I_STALL_EN.
module rv32i_top
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ACKI_n,
    input  logic        ACKD_n,
    input  logic [31:0] IDT,
    input  logic [31:0] IDT2,
    input  logic [2:0]  OINT_n,
    output logic [31:0] IAD,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    output logic        IACK_n,
    inout  wire  [31:0] DDT
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_load_val, w_wd, w_next_pc, w_dad;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [1:0]      w_size;
    logic            w_mem, w_write, w_mreq_out, w_rd_we, w_stall, w_rf_we;
    logic            w_unused;

    assign w_opcode = IDT[6:0];
    assign w_funct3 = IDT[14:12];
    assign w_imm_i  = {{20{IDT[31]}}, IDT[31:20]};
    assign w_imm_s  = {{20{IDT[31]}}, IDT[31:25], IDT[11:7]};
    assign w_imm_b  = {{19{IDT[31]}}, IDT[31], IDT[7], IDT[30:25], IDT[11:8], 1'b0};
    assign w_imm_u  = {IDT[31:12], 12'b0};
    assign w_imm_j  = {{11{IDT[31]}}, IDT[31], IDT[19:12], IDT[20], IDT[30:21], 1'b0};

    rv32i_regfile u_regfile (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (w_rf_we),
        .i_ra1   (IDT[19:15]),
        .i_ra2   (IDT[24:20]),
        .i_wa    (IDT[11:7]),
        .i_wd    (w_wd),
        .o_rd1   (w_rs1_val),
        .o_rd2   (w_rs2_val)
    );

    // Bus control and next PC never look at DDT, keeping the DDT read path out of this block.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        w_mem     = 1'b0;
        w_write   = 1'b0;
        w_size    = SZ_WORD;
        w_dad     = w_rs1_val + w_imm_i;
        case (w_opcode)
            OP_JAL:    w_next_pc = r_pc + w_imm_j;
            OP_JALR:   w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
            OP_BRANCH: if (br_taken(br_decode(w_funct3), w_rs1_val, w_rs2_val))
                           w_next_pc = r_pc + w_imm_b;
            OP_LOAD: begin
                w_mem  = 1'b1;
                w_size = size_from_f3(w_funct3);
            end
            OP_STORE: begin
                w_mem   = 1'b1;
                w_write = 1'b1;
                w_size  = size_from_f3(w_funct3);
                w_dad   = w_rs1_val + w_imm_s;
            end
            default: ;
        endcase
    end

    assign w_load_val = load_ext(w_funct3, DDT);

    always_comb begin
        w_rd_we = 1'b0;
        w_wd    = '0;
        case (w_opcode)
            OP_LUI:   begin w_rd_we = 1'b1; w_wd = w_imm_u;         end
            OP_AUIPC: begin w_rd_we = 1'b1; w_wd = r_pc + w_imm_u;  end
            OP_JAL,
            OP_JALR:  begin w_rd_we = 1'b1; w_wd = r_pc + 32'd4;    end
            OP_LOAD:  begin w_rd_we = 1'b1; w_wd = w_load_val;      end
            OP_IMM: begin
                w_rd_we = 1'b1;
                w_wd    = alu_exec(alu_decode(w_funct3, (w_funct3 == F3_SR) & IDT[30]),
                                   w_rs1_val, w_imm_i);
            end
            OP_OP: begin
                w_rd_we = 1'b1;
                w_wd    = alu_exec(alu_decode(w_funct3, IDT[30]), w_rs1_val, w_rs2_val);
            end
            default: ;
        endcase
    end

`ifdef RV32I_STALL_EN
    assign w_mreq_out = w_mem & ~ACKI_n;
    assign w_stall    = ACKI_n | (w_mreq_out & ACKD_n);
`else
    assign w_mreq_out = w_mem;
    assign w_stall    = 1'b0;
`endif

    assign w_rf_we = rst & ~w_stall & w_rd_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (!w_stall) begin
            r_pc <= w_next_pc;
        end
    end

    assign IAD    = r_pc;
    assign DAD    = w_dad;
    assign MREQ   = w_mreq_out;
    assign WRITE  = w_write;
    assign SIZE   = w_size;
    assign IACK_n = 1'b1;
    assign DDT    = (w_mreq_out && w_write) ? w_rs2_val : 'z;

    assign w_unused = ^{IDT2, OINT_n, ACKI_n, ACKD_n};

endmodule

// File: tb/tb_rv32i_top.sv
// Scoreboard bench for rv32i_top: an instruction-level reference model predicts every cycle's bus outputs.
`timescale 1ns/1ps
module tb_rv32i_top;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, acki_n, ackd_n;
    logic [31:0] idt, idt2;
    logic [2:0]  oint_n;
    logic [31:0] iad, dad;
    logic        mreq, write, iack_n;
    logic [1:0]  size;
    wire  [31:0] ddt;
    logic        ddt_oe;
    logic [31:0] ddt_drv;

    assign ddt = ddt_oe ? ddt_drv : 32'bz;
    always #5 clk = ~clk;

    rv32i_top #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .ACKI_n(acki_n), .ACKD_n(ackd_n),
        .IDT(idt), .IDT2(idt2), .OINT_n(oint_n),
        .IAD(iad), .DAD(dad), .MREQ(mreq), .WRITE(write), .SIZE(size),
        .IACK_n(iack_n), .DDT(ddt)
    );

    typedef struct {
        logic [31:0] iad;
        logic        mreq;
        logic        write;
        logic [1:0]  size;
        logic [31:0] dad;
        logic [31:0] ddt;
        bit          chk_dad;
    } exp_t;

    exp_t        q[$];
    string       tq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_regs [32];

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return 32'($signed(ins) >>> 20);
    endfunction
    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | {27'b0, ins[11:7]};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        logic [12:0] b;
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return 32'($signed(b));
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        logic [20:0] j;
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return 32'($signed(j));
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Instruction-level semantics, evaluated on the architectural state before the edge.
    task automatic model(input logic [31:0] ins, input logic [31:0] ld, input bit ai, input bit ad,
                         output exp_t e, output logic [31:0] npc, output bit we,
                         output logic [4:0] rd, output logic [31:0] wd, output bit stall);
        logic [31:0] a, b;
        logic [2:0]  f3;
        bit          mem, st, take;
        f3   = ins[14:12];
        rd   = ins[11:7];
        a    = m_regs[ins[19:15]];
        b    = m_regs[ins[24:20]];
        npc  = m_pc + 4;
        we   = 1'b0;
        wd   = '0;
        mem  = 1'b0;
        st   = 1'b0;
        take = 1'b0;
        e.dad  = '0;
        e.size = 2'b00;
        case (ins[6:0])
            7'h37: begin we = 1; wd = ins & 32'hFFFF_F000; end
            7'h17: begin we = 1; wd = m_pc + (ins & 32'hFFFF_F000); end
            7'h6F: begin we = 1; wd = m_pc + 4; npc = m_pc + imm_j(ins); end
            7'h67: begin we = 1; wd = m_pc + 4; npc = (a + imm_i(ins)) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) < $signed(b));
                    3'd5: take = ($signed(a) >= $signed(b));
                    3'd6: take = (a < b);
                    3'd7: take = (a >= b);
                    default: take = 1'b0;
                endcase
                if (take) npc = m_pc + imm_b(ins);
            end
            7'h03: begin
                mem = 1; we = 1; e.dad = a + imm_i(ins);
                case (f3)
                    3'd0: begin wd = 32'($signed(ld[7:0]));  e.size = 2'b10; end
                    3'd1: begin wd = 32'($signed(ld[15:0])); e.size = 2'b01; end
                    3'd4: begin wd = 32'(ld[7:0]);           e.size = 2'b10; end
                    3'd5: begin wd = 32'(ld[15:0]);          e.size = 2'b01; end
                    default: wd = ld;
                endcase
            end
            7'h23: begin
                mem = 1; st = 1; e.dad = a + imm_s(ins);
                e.size = (f3 == 3'd0) ? 2'b10 : (f3 == 3'd1) ? 2'b01 : 2'b00;
            end
            7'h13: begin we = 1; wd = arith(f3, (f3 == 3'd5) && ins[30], a, imm_i(ins)); end
            7'h33: begin we = 1; wd = arith(f3, ins[30], a, b); end
            default: ;
        endcase
`ifdef RV32I_STALL_EN
        e.mreq = mem && !ai;
        stall  = ai || (e.mreq && ad);
`else
        e.mreq = mem;
        stall  = 1'b0;
`endif
        e.iad     = m_pc;
        e.write   = st;
        e.chk_dad = mem;
        e.ddt     = (e.mreq && st) ? b : (e.mreq ? ld : 32'bz);
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] ld, input bit ai,
                        input bit ad, input bit rv, input string tag);
        exp_t        e;
        logic [31:0] npc, wd;
        logic [4:0]  rd;
        bit          we, stall;
        model(ins, ld, ai, ad, e, npc, we, rd, wd, stall);
        idt     = ins;
        acki_n  = ai;
        ackd_n  = ad;
        rst     = rv;
        ddt_drv = ld;
        ddt_oe  = e.mreq && !e.write;
        q.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        if (!rv) begin
            m_pc = RESET_PC;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else if (!stall) begin
            m_pc = npc;
            if (we && rd != 5'd0) m_regs[rd] = wd;
        end
        #1;
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic gen(input bit allow_mem, output logic [31:0] ins, output logic [31:0] ld);
        int unsigned k;
        logic [31:0] r;
        logic [2:0]  f3;
        logic [4:0]  s1;
        k  = allow_mem ? $urandom_range(0, 12) : $urandom_range(0, 8);
        r  = $urandom;
        ld = $urandom;
        f3 = 3'($urandom_range(0, 7));
        s1 = rreg();
        case (k)
            0: ins = {r[31:12], rreg(), 7'h37};
            1: ins = {r[31:12], rreg(), 7'h17};
            2: ins = enc_j(r[20:0], rreg());
            3: ins = enc_i(r[11:0], s1, 3'd0, rreg(), 7'h67);
            4: begin
                while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom_range(0, 7));
                ins = enc_b({r[12:1], 1'b0}, r[13] ? s1 : rreg(), s1, f3);
            end
            5, 6: begin
                if (f3 == 3'd1)      ins = enc_i({7'h00, r[4:0]}, s1, f3, rreg(), 7'h13);
                else if (f3 == 3'd5) ins = enc_i({1'b0, r[10], 5'h00, r[4:0]}, s1, f3, rreg(), 7'h13);
                else                 ins = enc_i(r[11:0], s1, f3, rreg(), 7'h13);
            end
            7: ins = enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00,
                           rreg(), s1, f3, rreg(), 7'h33);
            8: case (r[1:0])
                   2'd0: ins = 32'h0000_000F;
                   2'd1: ins = {r[31:7], 7'h73};
                   2'd2: ins = {r[31:7], 7'h7F};
                   default: ins = 32'h0010_0073;
               endcase
            9: begin
                while (f3 == 3'd3 || f3 > 3'd5) f3 = 3'($urandom_range(0, 5));
                ins = enc_i(r[11:0], s1, f3, rreg(), 7'h03);
            end
            default: ins = enc_s(r[11:0], rreg(), s1, 3'($urandom_range(0, 2)));
        endcase
    endtask

    initial begin : monitor
        exp_t  e;
        string tag;
        bit    ok;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                tag = tq.pop_front();
                ok  = (iad === e.iad) && (mreq === e.mreq) && (write === e.write) &&
                      (size === e.size) && (ddt === e.ddt) && (iack_n === 1'b1);
                if (e.chk_dad && (dad !== e.dad)) ok = 1'b0;
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL %s: iad=%h exp %h mreq=%b exp %b write=%b exp %b size=%b exp %b dad=%h exp %h ddt=%h exp %h iack_n=%b exp 1",
                             tag, iad, e.iad, mreq, e.mreq, write, e.write, size, e.size,
                             dad, e.chk_dad ? e.dad : dad, ddt, e.ddt, iack_n);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] ins, ld;
        bit          ai, ad, rv;
        rst = 1'b0; acki_n = 1'b0; ackd_n = 1'b0; idt = NOP; idt2 = '0;
        oint_n = 3'b111; ddt_oe = 1'b0; ddt_drv = '0;
        m_pc = RESET_PC;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        step(NOP, 0, 0, 0, 0, "reset_hold");
        step(NOP, 0, 0, 0, 0, "reset_hold2");
        step(32'h0050_0093, 0, 0, 0, 1, "addi_x1");
        step(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2, 7'h33), 0, 0, 0, 1, "add_x2");
        step({20'h08000, 5'd3, 7'h37}, 0, 0, 0, 1, "lui_x3");
        step(enc_s(12'd0, 5'd2, 5'd3, 3'd2), 0, 0, 0, 1, "sw_x2");
        step(enc_i(12'd0, 5'd3, 3'd0, 5'd4, 7'h03), 32'h0000_00F0, 0, 0, 1, "lb_x4");
        step(enc_s(12'd0, 5'd4, 5'd0, 3'd2), 0, 0, 0, 1, "sw_lb");
        step(enc_i(12'd0, 5'd3, 3'd4, 5'd4, 7'h03), 32'h0000_00F0, 0, 0, 1, "lbu_x4");
        step(enc_s(12'd0, 5'd4, 5'd0, 3'd2), 0, 0, 0, 1, "sw_lbu");
        step(enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0), 0, 0, 0, 1, "beq_back");
        step(enc_j(21'd16, 5'd1), 0, 0, 0, 1, "jal_x1");
        step(enc_s(12'd4, 5'd1, 5'd0, 3'd0), 0, 0, 0, 1, "sb_x1");
        step(enc_i(12'h040, 5'd0, 3'd0, 5'd5, 7'h13), 0, 0, 0, 1, "addi_x5");
        step(enc_i(12'd1, 5'd5, 3'd0, 5'd0, 7'h67), 0, 0, 0, 1, "jalr");
        step(NOP, 0, 0, 0, 1, "after_jalr");
`ifdef RV32I_STALL_EN
        step(enc_s(12'd0, 5'd2, 5'd3, 3'd2), 0, 0, 1, 1, "sw_stall1");
        step(enc_s(12'd0, 5'd2, 5'd3, 3'd2), 0, 0, 1, 1, "sw_stall2");
        step(enc_s(12'd0, 5'd2, 5'd3, 3'd2), 0, 0, 0, 1, "sw_ack");
        step(NOP, 0, 1, 0, 1, "ifetch_stall");
        step(NOP, 0, 0, 0, 1, "after_stall");
`endif
        for (int n = 0; n < 800; n++) begin
            rv = ($urandom_range(0, 99) != 0);
            gen(rv, ins, ld);
            ai = ($urandom_range(0, 9) == 0);
            ad = ($urandom_range(0, 3) == 0);
            step(ins, ld, ai, ad, rv, rv ? "random" : "random_reset");
        end
        ddt_oe = 1'b0;
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
